// File: rtl/image_buffer_ctrl.sv
// Ping-pong controller for a 32 KB dual-port image buffer split into two 16 KB banks.
// Latency: write port registered (1 cycle); read data valid 3 cycles after rd_start.
// Backpressure: rd_ready stalls the 2-entry output FIFO; the SPI write side has no backpressure.
//
// Ports:
//   clk, rst                  : single clock, synchronous active-high reset
//   wr_valid/wr_data/wr_sof   : SPI byte stream; wr_sof marks the first byte of a frame
//   bram_we/addr_wr/data_wr   : BRAM write port, address {bank, offset[13:0]}
//   bram_addr_rd/bram_data_rd : BRAM read port, data returns one cycle after address
//   rd_start                  : LCD frame request pulse
//   rd_valid/rd_ready/rd_data/rd_last : LCD byte stream, rd_last on the final byte
//   rd_busy                   : reader not idle
//   bank_full                 : per-bank full flag
//   frame_drop/frame_abort/rd_underrun : 1-cycle event pulses

// Generic synchronous FIFO with registered storage and occupancy count.
// Latency: a pushed word is visible at dout the cycle after the push.
// Backpressure: none internal; the caller must not push when full without popping.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Head slot is never overwritten while occupied, so dout is stable during a stall.
    assign dout = mem[rd_ptr];

endmodule

// Ping-pong image buffer controller: SPI fills one bank while the LCD drains the other.
// Latency: write 1 cycle; rd_start to first rd_valid 3 cycles, then 1 byte/cycle.
// Backpressure: rd_ready throttles read issue so at most 2 bytes are buffered or in flight.
module image_buffer_ctrl #(
    parameter int FRAME_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        wr_sof,
    output logic        bram_we,
    output logic [14:0] bram_addr_wr,
    output logic [7:0]  bram_data_wr,
    output logic [14:0] bram_addr_rd,
    input  logic [7:0]  bram_data_rd,
    input  logic        rd_start,
    input  logic        rd_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        rd_busy,
    output logic [1:0]  bank_full,
    output logic        frame_drop,
    output logic        frame_abort,
    output logic        rd_underrun
);

    localparam logic [13:0] LAST_OFF = 14'(FRAME_BYTES - 1);
    localparam bit          ONE_BYTE = (FRAME_BYTES == 1);

    // ------------------------------------------------------------------
    // Writer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;

    wr_state_t   wr_state, wr_state_nxt;
    logic        wr_bank, wr_bank_nxt;
    logic [13:0] wr_off, wr_off_nxt;     // offset of the next byte to write
    logic        we_nxt;
    logic [14:0] addr_wr_nxt;
    logic [7:0]  data_wr_nxt;
    logic        drop_nxt;
    logic        abort_nxt;
    logic        set_full;

    always_comb begin
        wr_state_nxt = wr_state;
        wr_bank_nxt  = wr_bank;
        wr_off_nxt   = wr_off;
        we_nxt       = 1'b0;
        addr_wr_nxt  = bram_addr_wr;
        data_wr_nxt  = bram_data_wr;
        drop_nxt     = 1'b0;
        abort_nxt    = 1'b0;
        set_full     = 1'b0;
        if (wr_valid) begin
            case (wr_state)
                W_IDLE, W_DROP: begin
                    if (wr_sof) begin
                        if (!bank_full[wr_bank]) begin
                            we_nxt      = 1'b1;
                            addr_wr_nxt = {wr_bank, 14'd0};
                            data_wr_nxt = wr_data;
                            if (ONE_BYTE) begin
                                set_full     = 1'b1;
                                wr_bank_nxt  = !wr_bank;
                                wr_off_nxt   = 14'd0;
                                wr_state_nxt = W_IDLE;
                            end else begin
                                wr_off_nxt   = 14'd1;
                                wr_state_nxt = W_FILL;
                            end
                        end else begin
                            drop_nxt     = 1'b1;
                            wr_state_nxt = W_DROP;
                        end
                    end
                end
                W_FILL: begin
                    we_nxt      = 1'b1;
                    data_wr_nxt = wr_data;
                    if (wr_sof) begin
                        // Restart the frame in place; the bank never becomes full
                        // with a truncated frame.
                        abort_nxt   = 1'b1;
                        addr_wr_nxt = {wr_bank, 14'd0};
                        wr_off_nxt  = 14'd1;
                    end else begin
                        addr_wr_nxt = {wr_bank, wr_off};
                        if (wr_off == LAST_OFF) begin
                            set_full     = 1'b1;
                            wr_bank_nxt  = !wr_bank;
                            wr_off_nxt   = 14'd0;
                            wr_state_nxt = W_IDLE;
                        end else begin
                            wr_off_nxt = wr_off + 14'd1;
                        end
                    end
                end
                default: wr_state_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state     <= W_IDLE;
            wr_bank      <= 1'b0;
            wr_off       <= 14'd0;
            bram_we      <= 1'b0;
            bram_addr_wr <= 15'd0;
            bram_data_wr <= 8'd0;
            frame_drop   <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            wr_state     <= wr_state_nxt;
            wr_bank      <= wr_bank_nxt;
            wr_off       <= wr_off_nxt;
            bram_we      <= we_nxt;
            bram_addr_wr <= addr_wr_nxt;
            bram_data_wr <= data_wr_nxt;
            frame_drop   <= drop_nxt;
            frame_abort  <= abort_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Reader
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rd_state_t;

    rd_state_t   rd_state, rd_state_nxt;
    logic        rd_bank, rd_bank_nxt;
    logic [13:0] rd_off, rd_off_nxt;     // offset presented on bram_addr_rd
    logic        inflight;               // BRAM data for last cycle's address arrives now
    logic        inflight_last;
    logic        issue;
    logic        issue_last;
    logic        underrun_nxt;
    logic        clr_full;
    logic        pop;
    logic        room;
    logic [8:0]  fifo_dout;
    logic [1:0]  fifo_cnt;

    assign pop = rd_valid && rd_ready;

    // Issue only if the byte can still land in the FIFO after this cycle's pop.
    assign room = (3'(fifo_cnt) + 3'(inflight)) < (3'd2 + 3'(pop));

    always_comb begin
        rd_state_nxt = rd_state;
        rd_bank_nxt  = rd_bank;
        rd_off_nxt   = rd_off;
        issue        = 1'b0;
        issue_last   = 1'b0;
        underrun_nxt = 1'b0;
        clr_full     = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (rd_start) begin
                    if (bank_full[rd_bank]) begin
                        rd_off_nxt   = 14'd0;
                        rd_state_nxt = R_RUN;
                    end else begin
                        underrun_nxt = 1'b1;
                    end
                end
            end
            R_RUN: begin
                if (room) begin
                    issue = 1'b1;
                    if (rd_off == LAST_OFF) begin
                        issue_last   = 1'b1;
                        rd_state_nxt = R_DRAIN;
                    end else begin
                        rd_off_nxt = rd_off + 14'd1;
                    end
                end
            end
            R_DRAIN: begin
                if (pop && rd_last) begin
                    clr_full     = 1'b1;
                    rd_bank_nxt  = !rd_bank;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state      <= R_IDLE;
            rd_bank       <= 1'b0;
            rd_off        <= 14'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_underrun   <= 1'b0;
            bank_full     <= 2'b00;
        end else begin
            rd_state      <= rd_state_nxt;
            rd_bank       <= rd_bank_nxt;
            rd_off        <= rd_off_nxt;
            inflight      <= issue;
            inflight_last <= issue_last;
            rd_underrun   <= underrun_nxt;
            // set_full and clr_full always target different banks.
            if (set_full) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (clr_full) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    assign bram_addr_rd = {rd_bank, rd_off};
    assign rd_busy      = (rd_state != R_IDLE);

    fifo #(
        .WIDTH (9),
        .DEPTH (2)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({inflight_last, bram_data_rd}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    assign rd_valid          = (fifo_cnt != 2'd0);
    assign {rd_last, rd_data} = fifo_dout;

endmodule

// File: tb/tb_image_buffer_ctrl.sv
module tb_image_buffer_ctrl;

    localparam int FB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_sof;
    logic        bram_we;
    logic [14:0] bram_addr_wr;
    logic [7:0]  bram_data_wr;
    logic [14:0] bram_addr_rd;
    logic [7:0]  bram_data_rd;
    logic        rd_start;
    logic        rd_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic        rd_busy;
    logic [1:0]  bank_full;
    logic        frame_drop;
    logic        frame_abort;
    logic        rd_underrun;

    always #5 clk = ~clk;

    image_buffer_ctrl #(.FRAME_BYTES(FB)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_sof       (wr_sof),
        .bram_we      (bram_we),
        .bram_addr_wr (bram_addr_wr),
        .bram_data_wr (bram_data_wr),
        .bram_addr_rd (bram_addr_rd),
        .bram_data_rd (bram_data_rd),
        .rd_start     (rd_start),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .rd_busy      (rd_busy),
        .bank_full    (bank_full),
        .frame_drop   (frame_drop),
        .frame_abort  (frame_abort),
        .rd_underrun  (rd_underrun)
    );

    // Dual-port BRAM with 1-cycle registered read.
    logic [7:0] mem [0:32767];
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr_wr] <= bram_data_wr;
        bram_data_rd <= mem[bram_addr_rd];
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wv;
        logic        sof;
        logic [7:0]  wd;
        logic        rs;
        logic        e_we;
        logic [14:0] e_awr;
        logic [7:0]  e_dwr;
        logic [1:0]  e_full;
        logic        e_drop;
        logic        e_abort;
        logic        e_under;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic wv, input logic sof, input logic [7:0] wd,
                                input logic rs, input logic e_we, input logic [14:0] e_awr,
                                input logic [7:0] e_dwr, input logic [1:0] e_full,
                                input logic e_drop, input logic e_abort, input logic e_under);
        vec_t v;
        v.wv = wv; v.sof = sof; v.wd = wd; v.rs = rs;
        v.e_we = e_we; v.e_awr = e_awr; v.e_dwr = e_dwr; v.e_full = e_full;
        v.e_drop = e_drop; v.e_abort = e_abort; v.e_under = e_under; v.e_busy = 1'b0;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue rd_start at the current negedge and consume one frame.
    task automatic read_frame(input logic [7:0] base, input logic bank,
                              input logic [1:0] full_after, input bit bp);
        int k = 0;
        int cyc = 0;
        int first = -1;
        int bubbles = 0;
        bit done = 0;
        bit stalled = 0;
        logic [7:0] held_d = 8'h00;
        logic held_l = 1'b0;
        logic [3:0] pat = 4'b1001;
        rd_start = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        cyc = 1;
        chk("rd_addr_first", 32'(bram_addr_rd), 32'({bank, 14'd0}));
        chk("rd_busy_run", 32'(rd_busy), 32'd1);
        while (!done && cyc < 200) begin
            if (rd_valid && first < 0) first = cyc;
            else if (!rd_valid && first >= 0) bubbles++;
            if (stalled)
                chk("stall_hold", 32'({rd_valid, rd_last, rd_data}), 32'({1'b1, held_l, held_d}));
            rd_ready = bp ? pat[cyc % 4] : 1'b1;
            if (rd_valid && rd_ready) begin
                chk($sformatf("rd_data[%0d]", k), 32'(rd_data), 32'(8'(base + 8'(k))));
                chk($sformatf("rd_last[%0d]", k), 32'(rd_last), 32'(k == FB - 1));
                if (k == FB - 1) done = 1;
                k++;
                stalled = 0;
            end else if (rd_valid) begin
                stalled = 1;
                held_d  = rd_data;
                held_l  = rd_last;
            end else begin
                stalled = 0;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b1;
        chk("frame_byte_count", 32'(k), 32'(FB));
        if (!bp) begin
            chk("first_valid_latency", 32'(first), 32'd3);
            chk("no_bubbles", 32'(bubbles), 32'd0);
        end
        chk("bank_full_release", 32'(bank_full), 32'(full_after));
        chk("rd_busy_release", 32'(rd_busy), 32'd0);
        chk("rd_valid_release", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int cyc;

        // Writer/control vectors, one per cycle, checked after the edge.
        add(0, 0, 8'h00, 1, 0, 15'd0, 8'd0, 2'b00, 0, 0, 1);   // underrun
        add(1, 0, 8'h55, 0, 0, 15'd0, 8'd0, 2'b00, 0, 0, 0);   // no sof: discard
        for (int i = 0; i < FB; i++)
            add(1, i == 0, 8'(i), 0, 1, 15'(i), 8'(i), (i == FB - 1) ? 2'b01 : 2'b00, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 15'd0, 8'd0, 2'b01, 0, 0, 0);
        for (int i = 0; i < FB; i++) begin
            if (i == 8) add(0, 0, 8'h00, 0, 0, 15'd0, 8'd0, 2'b01, 0, 0, 0);
            add(1, i == 0, 8'(8'h80 + i), 0, 1, 15'(16384 + i), 8'(8'h80 + i),
                (i == FB - 1) ? 2'b11 : 2'b01, 0, 0, 0);
        end
        add(1, 1, 8'hC0, 0, 0, 15'd0, 8'd0, 2'b11, 1, 0, 0);   // frame C dropped
        add(1, 0, 8'hC1, 0, 0, 15'd0, 8'd0, 2'b11, 0, 0, 0);
        add(1, 1, 8'hC2, 0, 0, 15'd0, 8'd0, 2'b11, 1, 0, 0);   // dropped again
        add(0, 0, 8'h00, 0, 0, 15'd0, 8'd0, 2'b11, 0, 0, 0);

        rst = 1'b1; wr_valid = 1'b0; wr_sof = 1'b0; wr_data = 8'h00;
        rd_start = 1'b0; rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_wr", 32'({bram_we, bram_addr_wr, bram_data_wr}), 32'd0);
        chk("reset_rd", 32'({bram_addr_rd, rd_valid, rd_data, rd_last, rd_busy}), 32'd0);
        chk("reset_flags", 32'({bank_full, frame_drop, frame_abort, rd_underrun}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            wr_valid = tbl[i].wv; wr_sof = tbl[i].sof; wr_data = tbl[i].wd;
            rd_start = tbl[i].rs;
            @(negedge clk);
            n_tests++;
            if (bram_we !== tbl[i].e_we ||
                (tbl[i].e_we && (bram_addr_wr !== tbl[i].e_awr || bram_data_wr !== tbl[i].e_dwr)) ||
                bank_full !== tbl[i].e_full || frame_drop !== tbl[i].e_drop ||
                frame_abort !== tbl[i].e_abort || rd_underrun !== tbl[i].e_under ||
                rd_busy !== tbl[i].e_busy) begin
                n_fail++;
                $display("FAIL vec%0d: got we=%b addr=%h data=%h full=%b drop=%b abort=%b under=%b busy=%b, expected we=%b addr=%h data=%h full=%b drop=%b abort=%b under=%b busy=%b",
                         i, bram_we, bram_addr_wr, bram_data_wr, bank_full, frame_drop,
                         frame_abort, rd_underrun, rd_busy, tbl[i].e_we, tbl[i].e_awr,
                         tbl[i].e_dwr, tbl[i].e_full, tbl[i].e_drop, tbl[i].e_abort,
                         tbl[i].e_under, tbl[i].e_busy);
            end
        end
        wr_valid = 1'b0; wr_sof = 1'b0; rd_start = 1'b0;

        // Frames come out in arrival order; B read with backpressure starting at L+1.
        read_frame(8'h00, 1'b0, 2'b10, 0);
        read_frame(8'h80, 1'b1, 2'b00, 1);

        // Mid-frame abort: 5 bytes, then a new sof with a full frame.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_sof = (i == 0); wr_data = 8'(8'h11 + i);
            @(negedge clk);
            chk($sformatf("abort_pre_addr[%0d]", i), 32'({bram_we, bram_addr_wr}), 32'({1'b1, 15'(i)}));
            chk($sformatf("abort_pre_pulse[%0d]", i), 32'({frame_abort, frame_drop}), 32'd0);
        end
        for (int i = 0; i < FB; i++) begin
            wr_valid = 1'b1; wr_sof = (i == 0); wr_data = 8'(8'h40 + i);
            @(negedge clk);
            chk($sformatf("abort_addr[%0d]", i), 32'({bram_we, bram_addr_wr}), 32'({1'b1, 15'(i)}));
            chk($sformatf("abort_pulse[%0d]", i), 32'(frame_abort), 32'(i == 0));
            chk($sformatf("abort_full[%0d]", i), 32'(bank_full), (i == FB - 1) ? 32'd1 : 32'd0);
        end
        wr_valid = 1'b0; wr_sof = 1'b0;
        read_frame(8'h40, 1'b0, 2'b00, 0);

        // Underrun with both banks empty.
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        chk("underrun_pulse", 32'(rd_underrun), 32'd1);
        chk("underrun_busy", 32'(rd_busy), 32'd0);
        @(negedge clk);
        chk("underrun_one_cycle", 32'({rd_underrun, rd_busy}), 32'd0);

        // Frame D into bank 1, then reset during readout.
        for (int i = 0; i < FB; i++) begin
            wr_valid = 1'b1; wr_sof = (i == 0); wr_data = 8'(8'h60 + i);
            @(negedge clk);
        end
        wr_valid = 1'b0; wr_sof = 1'b0;
        chk("frame_d_full", 32'(bank_full), 32'b10);
        chk("frame_d_last_addr", 32'(bram_addr_wr), 32'h400F);
        rd_ready = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 7 && cyc < 50) begin
            if (rd_valid) begin
                chk($sformatf("rst_rd_data[%0d]", k), 32'(rd_data), 32'(8'(8'h60 + k)));
                k++;
                if (k == 7) rst = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rst_read_bytes", 32'(k), 32'd7);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_rd_busy", 32'(rd_busy), 32'd0);
        rst = 1'b0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        chk("rst_then_underrun", 32'({rd_underrun, rd_busy}), 32'b10);
        @(negedge clk);
        chk("rst_no_stale_valid", 32'(rd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
